// File: rtl/mtc_pkg.sv
// Shared constants for multi_timer: channel FSM encoding, register map and CTRL field layout.
package mtc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;
  localparam int unsigned CTRL_IM   = 3;
  localparam int unsigned CTRL_PSC  = 8;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // STATUS sits directly after the last channel's four-word block.
  function automatic int unsigned status_word(input int unsigned n_ch);
    return 4 * n_ch;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// Register bus and interrupt bundle for multi_timer; the bridge/CPU side is the master.
interface multi_timer_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] Addr;
  logic              WE;
  logic [31:0]       Din;
  logic [31:0]       Dout;
  logic [N_CH-1:0]   IRQ;
  logic              IRQ_any;

  modport master (output Addr, WE, Din, input Dout, IRQ, IRQ_any);
  modport slave  (input Addr, WE, Din, output Dout, IRQ, IRQ_any);
endinterface

// File: rtl/multi_timer_ch.sv
// One multi_timer channel: CTRL/PRESET registers, down-counter FSM and interrupt flag.
// Defining MTC_PRESCALER_EN adds the CTRL[15:8] tick prescaler.
module multi_timer_ch
  import mtc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_we,
  input  logic        preset_we,
  input  logic        status_clr,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic        flag,
  output logic        irq
);

  logic [1:0]       state;
  logic             en;
  logic             im;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             periodic;
  logic             tick;
  logic             expire;
  logic             flag_clr;
  logic [7:0]       psc_wdata;
  logic             unused_wdata;

  assign psc_wdata    = wdata[CTRL_PSC +: 8];
  assign unused_wdata = ^{wdata, psc_wdata};
  assign periodic     = (mode == MODE_PERIODIC);
  assign expire       = (state == ST_CNT) && en && tick && (count <= CNT_W'(1));
  assign flag_clr     = ctrl_we || preset_we || status_clr || ((state == ST_INT) && periodic);

`ifdef MTC_PRESCALER_EN
  logic [7:0] psc;
  logic [7:0] psc_cnt;

  assign tick = (psc_cnt == psc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else begin
      if (ctrl_we) psc <= psc_wdata;
      if (!en || (state == ST_LOAD) || (state == ST_INT)) psc_cnt <= '0;
      else if (state == ST_CNT) psc_cnt <= tick ? '0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      en     <= 1'b0;
      im     <= 1'b0;
      mode   <= MODE_ONESHOT;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      // A CPU CTRL write in the INT cycle overrides the one-shot EN auto-clear.
      if (ctrl_we) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE +: 2];
        im   <= wdata[CTRL_IM];
      end else if ((state == ST_INT) && !periodic) begin
        en <= 1'b0;
      end
      if (preset_we) preset <= wdata[CNT_W-1:0];

      if (expire)        flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;

      case (state)
        ST_IDLE: if (en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) state <= ST_IDLE;
          else if (tick) begin
            if (count > CNT_W'(1)) count <= count - CNT_W'(1);
            else begin
              count <= '0;
              state <= ST_INT;
            end
          end
        end
        // Periodic reload happens here rather than via LOAD so the period is PRESET+1.
        ST_INT: begin
          if (periodic) begin
            count <= preset;
            state <= ST_CNT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[CTRL_EN]         = en;
    ctrl_rd[CTRL_MODE +: 2]  = mode;
    ctrl_rd[CTRL_IM]         = im;
`ifdef MTC_PRESCALER_EN
    ctrl_rd[CTRL_PSC +: 8]   = psc;
`endif
  end

  assign preset_rd = 32'(preset);
  assign count_rd  = 32'(count);
  assign irq       = flag & im;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: N_CH programmable down-counter channels behind a word-addressed register bus.
// Define MTC_PRESCALER_EN to enable the per-channel CTRL[15:8] prescaler.
module multi_timer
  import mtc_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic          clk,
  input logic          reset,
  multi_timer_if.slave bus
);

  localparam int unsigned       IDX_W       = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_word(N_CH));

  logic [N_CH-1:0] flags;
  logic [N_CH-1:0] irqs;
  logic [31:0]     ch_rd [N_CH];
  logic            status_sel;
  logic [31:0]     dout;

  assign status_sel = (bus.Addr == STATUS_ADDR);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic        sel;
    logic        sel_ctrl;
    logic        sel_preset;
    logic        sel_count;
    logic [31:0] ctrl_rd;
    logic [31:0] preset_rd;
    logic [31:0] count_rd;

    assign sel        = (bus.Addr[ADDR_W-1:2] == IDX_W'(c));
    assign sel_ctrl   = sel && (bus.Addr[1:0] == OFF_CTRL);
    assign sel_preset = sel && (bus.Addr[1:0] == OFF_PRESET);
    assign sel_count  = sel && (bus.Addr[1:0] == OFF_COUNT);

    multi_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (bus.WE && sel_ctrl),
      .preset_we (bus.WE && sel_preset),
      .status_clr(bus.WE && status_sel && bus.Din[c]),
      .wdata     (bus.Din),
      .ctrl_rd   (ctrl_rd),
      .preset_rd (preset_rd),
      .count_rd  (count_rd),
      .flag      (flags[c]),
      .irq       (irqs[c])
    );

    assign ch_rd[c] = sel_ctrl   ? ctrl_rd   :
                      sel_preset ? preset_rd :
                      sel_count  ? count_rd  : '0;
  end

  always_comb begin
    dout = '0;
    if (status_sel) dout = 32'(flags);
    for (int unsigned i = 0; i < N_CH; i++) dout = dout | ch_rd[i];
  end

  assign bus.Dout    = dout;
  assign bus.IRQ     = irqs;
  assign bus.IRQ_any = |irqs;

endmodule
